// File: rtl/oven_pkg.sv
// Shared definitions for the oven bake controller and the front-panel block.
package oven_pkg;

  localparam int unsigned TEMP_W = 11;
  localparam int unsigned TIME_W = 16;

  // Defaults shared with the front-panel block
  localparam int unsigned DefaultAmbient = 60;
  localparam int unsigned DefaultMaxTemp = 1000;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPreheat = 2'd1,
    StBake    = 2'd2,
    StDone    = 2'd3
  } oven_state_e;

endpackage

// File: rtl/oven_temp_model.sv
// Saturating heat/cool accumulator modelling the oven temperature.
// The next value is exposed combinationally so the sequencer can act on the
// temperature the oven will have after the current tick.
module oven_temp_model
  import oven_pkg::*;
#(
  parameter int unsigned AMBIENT   = DefaultAmbient,
  parameter int unsigned MAX_TEMP  = DefaultMaxTemp,
  parameter int unsigned HEAT_STEP = 2,
  parameter int unsigned COOL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              heater_on,
  output logic [TEMP_W-1:0] current_temp,
  output logic [TEMP_W-1:0] next_temp
);

  localparam logic [TEMP_W:0] Ambient   = (TEMP_W+1)'(AMBIENT);
  localparam logic [TEMP_W:0] MaxTemp   = (TEMP_W+1)'(MAX_TEMP);
  localparam logic [TEMP_W:0] HeatStep  = (TEMP_W+1)'(HEAT_STEP);
  localparam logic [TEMP_W:0] CoolStep  = (TEMP_W+1)'(COOL_STEP);
  localparam logic [TEMP_W:0] CoolFloor = (TEMP_W+1)'(AMBIENT + COOL_STEP);

  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [TEMP_W:0]   temp_ext, wide;

  // Next temperature at one extra bit, clamped, then saturated to TEMP_W bits
  always_comb begin
    temp_ext = {1'b0, temp_q};
    wide     = temp_ext;
    if (heater_on) begin
      wide = temp_ext + HeatStep;
      if (wide > MaxTemp) wide = MaxTemp;
    end else if (temp_ext < CoolFloor) begin
      wide = Ambient;
    end else begin
      wide = temp_ext - CoolStep;
    end
    next_temp = wide[TEMP_W] ? '1 : wide[TEMP_W-1:0];
    temp_d    = tick ? next_temp : temp_q;
  end

  // Temperature register, updated only on an effective tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) temp_q <= Ambient[TEMP_W-1:0];
    else     temp_q <= temp_d;
  end

  assign current_temp = temp_q;

endmodule

// File: rtl/oven_bake_controller.sv
// Bake-cycle sequencer: preheat, hold with hysteresis while counting down,
// then a timed done alarm. Optional door interlock under OVEN_DOOR_EN.
module oven_bake_controller
  import oven_pkg::*;
#(
  parameter int unsigned AMBIENT     = DefaultAmbient,
  parameter int unsigned MAX_TEMP    = DefaultMaxTemp,
  parameter int unsigned HEAT_STEP   = 2,
  parameter int unsigned COOL_STEP   = 1,
  parameter int unsigned HYST        = 10,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              cancel,
`ifdef OVEN_DOOR_EN
  input  logic              door_open,
`endif
  input  logic [TEMP_W-1:0] target_temp,
  input  logic [TIME_W-1:0] bake_time,
  output logic              heater_on,
  output logic [TEMP_W-1:0] current_temp,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        state,
  output logic              done
);

  localparam int unsigned AlarmW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [TEMP_W-1:0] MaxTemp = TEMP_W'(MAX_TEMP);
  localparam logic [TEMP_W:0]   Hyst    = (TEMP_W+1)'(HYST);

  oven_state_e       state_q, state_d;
  logic              heater_q, heater_d;
  logic              done_q, done_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TEMP_W-1:0] target_q, target_d;
  logic [AlarmW-1:0] alarm_q, alarm_d;
  logic              temp_tick, model_heater, door_block, start_ok;
  logic [TEMP_W-1:0] next_temp, temp_now;
  logic [TEMP_W:0]   hyst_floor;

`ifdef OVEN_DOOR_EN
  assign door_block = door_open && ((state_q == StPreheat) || (state_q == StBake));
`else
  assign door_block = 1'b0;
`endif

  assign start_ok     = start && ((state_q == StIdle) || (state_q == StDone));
  // An open door cools the oven regardless of the registered heater state
  assign model_heater = heater_q && !door_block;
  assign hyst_floor   = ({1'b0, target_q} > Hyst) ? ({1'b0, target_q} - Hyst) : '0;

  oven_temp_model #(
    .AMBIENT   (AMBIENT),
    .MAX_TEMP  (MAX_TEMP),
    .HEAT_STEP (HEAT_STEP),
    .COOL_STEP (COOL_STEP)
  ) u_temp_model (
    .clk          (clk),
    .rst          (rst),
    .tick         (temp_tick),
    .heater_on    (model_heater),
    .current_temp (temp_now),
    .next_temp    (next_temp)
  );

  // Next-state logic: cancel beats start beats tick; start/cancel swallow a tick
  always_comb begin
    state_d   = state_q;
    heater_d  = heater_q;
    done_d    = done_q;
    time_d    = time_q;
    target_d  = target_q;
    alarm_d   = alarm_q;
    temp_tick = 1'b0;
    if (cancel) begin
      state_d  = StIdle;
      heater_d = 1'b0;
      done_d   = 1'b0;
      time_d   = '0;
      alarm_d  = '0;
    end else if (start_ok) begin
      state_d  = StPreheat;
      heater_d = 1'b1;
      done_d   = 1'b0;
      time_d   = bake_time;
      target_d = (target_temp > MaxTemp) ? MaxTemp : target_temp;
      alarm_d  = '0;
    end else if (door_block) begin
      heater_d  = 1'b0;
      temp_tick = tick;
    end else if (tick) begin
      temp_tick = 1'b1;
      unique case (state_q)
        StIdle: heater_d = 1'b0;
        StPreheat: begin
          if (next_temp >= target_q) begin
            state_d  = StBake;
            heater_d = 1'b0;
          end else begin
            heater_d = 1'b1;
          end
        end
        StBake: begin
          if (next_temp >= target_q)             heater_d = 1'b0;
          else if ({1'b0, next_temp} < hyst_floor) heater_d = 1'b1;
          if (time_q <= TIME_W'(1)) begin
            time_d   = '0;
            state_d  = StDone;
            heater_d = 1'b0;
            done_d   = 1'b1;
            alarm_d  = AlarmW'(ALARM_TICKS);
          end else begin
            time_d = time_q - TIME_W'(1);
          end
        end
        StDone: begin
          heater_d = 1'b0;
          if (alarm_q <= AlarmW'(1)) begin
            alarm_d = '0;
            state_d = StIdle;
            done_d  = 1'b0;
          end else begin
            alarm_d = alarm_q - AlarmW'(1);
          end
        end
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      heater_q <= 1'b0;
      done_q   <= 1'b0;
      time_q   <= '0;
      target_q <= TEMP_W'(AMBIENT);
      alarm_q  <= '0;
    end else begin
      state_q  <= state_d;
      heater_q <= heater_d;
      done_q   <= done_d;
      time_q   <= time_d;
      target_q <= target_d;
      alarm_q  <= alarm_d;
    end
  end

  assign heater_on    = heater_q;
  assign current_temp = temp_now;
  assign time_left    = time_q;
  assign state        = state_q;
  assign done         = done_q;

endmodule

// File: tb/tb_oven_bake_controller.sv
// Scoreboard bench for oven_bake_controller: stimulus pushes expected outputs
// from a behavioural model, an independent monitor pops and compares.
module tb_oven_bake_controller;

  localparam int Amb    = 60;
  localparam int MaxT   = 1000;
  localparam int Heat   = 2;
  localparam int Cool   = 1;
  localparam int Hyst   = 10;
  localparam int AlarmT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        door_open = 1'b0;
  logic [10:0] target_temp = '0;
  logic [15:0] bake_time = '0;
  logic        heater_on;
  logic [10:0] current_temp;
  logic [15:0] time_left;
  logic [1:0]  state;
  logic        done;

  always #5 clk = ~clk;

  oven_bake_controller #(
    .AMBIENT     (Amb),
    .MAX_TEMP    (MaxT),
    .HEAT_STEP   (Heat),
    .COOL_STEP   (Cool),
    .HYST        (Hyst),
    .ALARM_TICKS (AlarmT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .cancel       (cancel),
`ifdef OVEN_DOOR_EN
    .door_open    (door_open),
`endif
    .target_temp  (target_temp),
    .bake_time    (bake_time),
    .heater_on    (heater_on),
    .current_temp (current_temp),
    .time_left    (time_left),
    .state        (state),
    .done         (done)
  );

  typedef struct {
    int cyc;
    int st;
    int heat;
    int temp;
    int tl;
    int dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Behavioural model: 0 idle, 1 preheat, 2 bake, 3 done
  int m_st, m_heat, m_temp, m_tl, m_tgt, m_alarm, m_done;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    m_st = 0; m_heat = 0; m_temp = Amb; m_tl = 0; m_tgt = Amb; m_alarm = 0; m_done = 0;
  endtask

  task automatic model_step(input int t, input int s, input int c, input int tt, input int bt,
                            input int d);
    int nt;
    if (c != 0) begin
      m_st = 0; m_heat = 0; m_tl = 0; m_alarm = 0; m_done = 0;
    end else if (s != 0 && (m_st == 0 || m_st == 3)) begin
      m_tgt = imin(tt, MaxT); m_tl = bt; m_st = 1; m_heat = 1; m_done = 0;
    end else if (d != 0 && (m_st == 1 || m_st == 2)) begin
      m_heat = 0;
      if (t != 0) m_temp = imax(m_temp - Cool, Amb);
    end else if (t != 0) begin
      nt = (m_heat != 0) ? imin(m_temp + Heat, MaxT) : imax(m_temp - Cool, Amb);
      if (m_st == 0) begin
        m_heat = 0;
      end else if (m_st == 1) begin
        if (nt >= m_tgt) begin m_st = 2; m_heat = 0; end
        else m_heat = 1;
      end else if (m_st == 2) begin
        if (nt >= m_tgt) m_heat = 0;
        else if (nt < imax(m_tgt - Hyst, 0)) m_heat = 1;
        if (m_tl <= 1) begin
          m_tl = 0; m_st = 3; m_heat = 0; m_done = 1; m_alarm = AlarmT;
        end else begin
          m_tl = m_tl - 1;
        end
      end else begin
        m_heat = 0;
        m_alarm = m_alarm - 1;
        if (m_alarm <= 0) begin m_alarm = 0; m_st = 0; m_done = 0; end
      end
      m_temp = nt;
    end
  endtask

  // One clock cycle of stimulus; expectation is tagged with the edge it applies to
  task automatic drive(input int t, input int s, input int c, input int tt, input int bt,
                       input int d);
    exp_t x;
    @(negedge clk);
    tick = t[0]; start = s[0]; cancel = c[0];
    target_temp = 11'(tt); bake_time = 16'(bt); door_open = d[0];
    model_step(t, s, c, tt & 2047, bt & 65535, d);
    x.cyc = cyc + 1; x.st = m_st; x.heat = m_heat; x.temp = m_temp; x.tl = m_tl; x.dn = m_done;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom_range(0, 2047), $urandom_range(0, 99), 0);
  endtask

  task automatic tk(input int gap);
    drive(1, 0, 0, $urandom_range(0, 2047), $urandom_range(0, 99), 0);
    idle(gap);
  endtask

  // Monitor: compares every tagged expectation one step after its clock edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        if (int'(state) != e.st || int'(heater_on) != e.heat || int'(current_temp) != e.temp ||
            int'(time_left) != e.tl || int'(done) != e.dn) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: st/heat/temp/time/done got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                   cyc, state, heater_on, current_temp, time_left, done,
                   e.st, e.heat, e.temp, e.tl, e.dn);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Target 70, bake 3: preheat in 5 ticks, done on tick 8, idle 5 ticks later
    drive(0, 1, 0, 70, 3, 0);
    for (int i = 0; i < 14; i++) tk(3);

    // Target 100, long bake: hysteresis oscillation
    drive(0, 1, 0, 100, 60, 0);
    for (int i = 0; i < 85; i++) tk(1);

    // Start during preheat with a different target is ignored
    drive(0, 1, 0, 200, 5, 0);
    for (int i = 0; i < 10; i++) tk(0);
    drive(1, 1, 0, 90, 1, 0);
    for (int i = 0; i < 80; i++) tk(0);

    // Cancel in bake at time_left 40, together with a tick, then restart
    drive(0, 1, 0, 80, 45, 0);
    guard = 0;
    while (!(m_st == 2 && m_tl == 40) && guard < 300) begin tk(0); guard++; end
    drive(1, 0, 1, 0, 0, 0);
    idle(2);
    drive(1, 1, 0, 75, 2, 0);
    for (int i = 0; i < 20; i++) tk(0);

    // Clamp: 1500 -> 1000, hysteresis near the ceiling exercises saturation
    drive(0, 1, 0, 1500, 30, 0);
    guard = 0;
    while (m_st != 0 && guard < 700) begin tk(0); guard++; end

`ifdef OVEN_DOOR_EN
    // Door open for 3 ticks in bake at time_left 10 freezes countdown
    cancel = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 70, 20, 0);
    guard = 0;
    while (!(m_st == 2 && m_tl == 10) && guard < 900) begin tk(0); guard++; end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1);
      drive(0, 1, 0, 300, 7, 1);
    end
    for (int i = 0; i < 15; i++) tk(1);
`endif

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      int t, s, c, tt, bt, d;
      t  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      s  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      c  = ($urandom_range(0, 79) == 0) ? 1 : 0;
      tt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2047) : $urandom_range(40, 300);
      bt = $urandom_range(0, 12);
      d  = 0;
`ifdef OVEN_DOOR_EN
      d  = ($urandom_range(0, 9) == 0) ? 1 : 0;
`endif
      drive(t, s, c, tt, bt, d);
    end

    // Asynchronous reset mid-bake takes effect without a clock edge
    drive(0, 1, 0, 150, 20, 0);
    for (int i = 0; i < 50; i++) tk(0);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; cancel = 1'b0; door_open = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (state != 2'd0 || heater_on != 1'b0 || current_temp != 11'(Amb) ||
        time_left != 16'd0 || done != 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: st/heat/temp/time/done got %0d/%0d/%0d/%0d/%0d want 0/0/%0d/0/0",
               state, heater_on, current_temp, time_left, done, Amb);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 1, 0, 64, 1, 0);
    for (int i = 0; i < 10; i++) tk(0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oven_bake_controller.md
# oven_bake_controller

Bake-cycle sequencer and thermal model that consumes the target temperature and bake time produced by the oven front-panel/display block. Once started, it preheats, holds temperature with hysteresis while counting the bake time down, then raises a timed done alarm. It drives the heater enable and reports live temperature and remaining time back to the display block. All sequencing advances on a 1 Hz `tick` strobe generated by the existing clock-divider logic.

## Interface
Parameters:
- `AMBIENT`, 60: idle/floor temperature (°F).
- `MAX_TEMP`, 1000: temperature ceiling. Latched target is clamped to this value.
- `HEAT_STEP`, 2: temperature rise per tick while the heater is on.
- `COOL_STEP`, 1: temperature fall per tick while the heater is off.
- `HYST`, 10: hysteresis band below target during BAKE.
- `ALARM_TICKS`, 5: number of ticks the DONE state lasts.

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk`-wide strobe, once per second.
- `start` in 1: level or pulse; acted on in IDLE or DONE only.
- `cancel` in 1: abort request.
- `target_temp` in 11: requested temperature, sampled at start.
- `bake_time` in 16: bake duration in seconds, sampled at start.
- `heater_on` out 1: heating element enable.
- `current_temp` out 11: modelled oven temperature.
- `time_left` out 16: remaining bake seconds.
- `state` out 2: 0 = IDLE, 1 = PREHEAT, 2 = BAKE, 3 = DONE.
- `done` out 1: high throughout DONE.

## Operation
- Reset values: `state` = IDLE, `current_temp` = `AMBIENT`, `time_left` = 0, `heater_on` = 0, `done` = 0, latched target = `AMBIENT`, alarm counter = 0.
- Priority within a cycle: `rst` > `cancel` > `start` > `tick` processing.
- `cancel` (any state): next edge goes to IDLE with `heater_on` = 0 and `time_left` = 0. Temperature is held for that cycle.
- `start` in IDLE or DONE:
  - Latch `min(target_temp, MAX_TEMP)` and `bake_time`.
  - Set `time_left` = `bake_time`, go to PREHEAT, set `heater_on` = 1, clear `done`.
  - `start` in PREHEAT or BAKE is ignored.
- Temperature model, on `tick` only, using the `heater_on` value from before the tick:
  - Heater on: `next_temp` = `min(current_temp + HEAT_STEP, MAX_TEMP)`.
  - Heater off: `next_temp` = `max(current_temp - COOL_STEP, AMBIENT)`.
  - Computed at 12 bits, then saturated back to 11 bits.
- PREHEAT, on tick: if `next_temp >= target`, go to BAKE with `heater_on` = 0. Otherwise stay with `heater_on` = 1. A target at or below the current temperature enters BAKE on the first tick.
- BAKE, on tick:
  - Heater: if `next_temp >= target`, `heater_on` = 0. Else if `next_temp < target - HYST` (with `target - HYST` floored at 0), `heater_on` = 1. Otherwise hold.
  - Countdown: if `time_left <= 1`, set `time_left` = 0, go to DONE, `heater_on` = 0, `done` = 1, alarm counter = `ALARM_TICKS`. Otherwise decrement `time_left`.
  - A `bake_time` of 0 therefore exits on the first BAKE tick.
- DONE, on tick: decrement the alarm counter. When it reaches 0, go to IDLE and clear `done`.
- IDLE/DONE: heater off; temperature cools toward `AMBIENT` on each tick.

## Timing
- All outputs are registered. Effects appear on the `clk` edge of the `tick` cycle (or of the `start`/`cancel` cycle), with no further latency.
- Between ticks, `current_temp`, `time_left` and the alarm counter are stable.
- `tick` asserted together with `start` or `cancel`: the tick is consumed without effect on temperature or timers.
- `rst` asserted mid-bake forces the reset values immediately, with no clock required.

## Configuration
- Macro `OVEN_DOOR_EN`.
- Defined:
  - Adds input `door_open` (1 bit).
  - While `door_open` = 1 in PREHEAT or BAKE: `heater_on` is forced to 0, `time_left` is frozen, and the FSM does not advance. Temperature cools by `COOL_STEP` per tick.
  - Closing the door resumes in the same state on the next tick.
  - `start` is ignored while the door is open.
- Undefined: the port does not exist and behaviour is exactly as above.

## Structure
- Package `oven_pkg` holds:
  - the state encoding (IDLE/PREHEAT/BAKE/DONE),
  - `TEMP_W` = 11 and `TIME_W` = 16,
  - default values for `AMBIENT` and `MAX_TEMP`, shared with the front-panel block.
- Sub-module `oven_temp_model`: the saturating heat/cool accumulator. It takes `tick` and `heater_on`, outputs `current_temp`, and exposes `next_temp` combinationally to the FSM.

## Test plan
- Reset, then `start` with target 70 and `bake_time` 3 → temperature steps 62, 64, 66, 68, 70. BAKE is entered on tick 5 with the heater off. `time_left` steps 2, 1, 0, DONE on the 8th tick, IDLE 5 ticks later.
- Target 100, long bake → in BAKE the heater turns off at 100, cools to 89, and turns on when `next_temp` reaches 89 (below 90). Temperature oscillates within 89–101.
- `cancel` during BAKE with `time_left` 40 → next edge: IDLE, `heater_on` = 0, `time_left` = 0. A later `start` is accepted.
- `start` asserted during PREHEAT with a new target → ignored; the latched target is unchanged.
- Target 1500 → clamped to 1000. Temperature saturates at 1000, never wraps, and BAKE is entered.
- With `OVEN_DOOR_EN`: `door_open` for 3 ticks in BAKE at `time_left` 10 → `time_left` stays 10, heater is 0, temperature drops by 3. Countdown resumes after close.
